psg_bus_master: RTL

Bus initiator for the TurboSound PSG pair. It accepts register read/write requests from the host side (CPU port decoder or a register-dump player) through a valid/ready FIFO. It then sequences them onto the AY/YM BDIR/BC/data bus with programmable phase hold and gap times. Chip-select latch cycles (1111 111N) are inserted automatically whenever the target chip differs from the currently selected one.

---
 rtl/psg_bus_pkg.sv | 32 +++
 rtl/psg_req_fifo.sv | 64 ++++++
 rtl/psg_bus_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/psg_bus_pkg.sv
// Shared types and constants for the TurboSound PSG bus master: sequencer states,
// AY/YM bus codes and the request record carried through the request FIFO.
package psg_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SEL_GAP,
    ST_ADDR,
    ST_ADDR_GAP,
    ST_DATA,
    ST_DATA_GAP
  } psg_state_t;

  // {BDIR, BC}
  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] BUS_LATCH = 2'b11;

  localparam logic [6:0] TS_SEL_PREFIX = 7'h7F;

  typedef struct packed {
    logic       wr;
    logic       chip;
    logic [3:0] addr;
    logic [7:0] data;
  } psg_req_t;

  localparam int REQ_W = $bits(psg_req_t);

endpackage

// File: rtl/psg_req_fifo.sv
// Request FIFO for the PSG bus master. Full/empty are registered so the host-side
// ready never depends combinationally on the sequencer's pop.
module psg_req_fifo
  import psg_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [REQ_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [REQ_W-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage needs no reset; the registered flags gate every read of it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;

endmodule

// File: rtl/psg_bus_master.sv
// Sequences queued register reads/writes onto the AY/YM BDIR/BC/data bus of a
// TurboSound pair, inserting chip-select latch cycles when the target changes.
//   state       | meaning
//   ST_IDLE     | bus inactive, pop next request when FIFO non-empty
//   ST_SEL      | latch 1111_111N to switch the active chip
//   ST_SEL_GAP  | inactive clocks after the select phase
//   ST_ADDR     | latch the register number
//   ST_ADDR_GAP | inactive clocks after the address phase
//   ST_DATA     | write (10) or read (01) phase; read samples DI on last clock
//   ST_DATA_GAP | inactive clocks after the data phase, then next request
module psg_bus_master
  import psg_bus_pkg::*;
#(
  parameter int HOLD       = 2,
  parameter int GAP        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_wr_i,
  input  logic       req_chip_i,
  input  logic [3:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic       bdir_o,
  output logic       bc_o,
  output logic [7:0] do_o,
  input  logic [7:0] di_i
);

  localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW     = $clog2(MAX_HG + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit HAS_GAP = (GAP > 0);

  psg_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  psg_req_t         req_q, req_d, head;
  logic [REQ_W-1:0] head_bits;
  logic             cur_chip_q, cur_chip_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [9:0]       bus_q, bus_d;
  logic             fifo_full, fifo_empty;
  logic             pop, dispatch, tc;

  psg_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (req_valid_i),
    .push_data_i({req_wr_i, req_chip_i, req_addr_i, req_data_i}),
    .pop_i      (pop),
    .pop_data_o (head_bits),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign head = psg_req_t'(head_bits);
  assign tc   = (cnt_q == '0);

  function automatic logic [9:0] bus_word(input psg_state_t st, input psg_req_t rq);
    logic [9:0] w;
    w = {BUS_IDLE, 8'h00};
    case (st)
      ST_SEL:  w = {BUS_LATCH, TS_SEL_PREFIX, rq.chip};
      ST_ADDR: w = {BUS_LATCH, 4'h0, rq.addr};
      ST_DATA: w = rq.wr ? {BUS_WRITE, rq.data} : {BUS_READ, 8'h00};
      default: w = {BUS_IDLE, 8'h00};
    endcase
    return w;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    cur_chip_d = cur_chip_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    pop        = 1'b0;
    dispatch   = 1'b0;
    if (!tc) cnt_d = cnt_q - 1'b1;

    case (state_q)
      ST_IDLE: dispatch = 1'b1;
      ST_SEL: begin
        if (tc) begin
          cur_chip_d = req_q.chip;
          if (HAS_GAP) begin
            state_d = ST_SEL_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_ADDR;
            cnt_d   = HOLD_LD;
          end
        end
      end
      ST_SEL_GAP: begin
        if (tc) begin
          state_d = ST_ADDR;
          cnt_d   = HOLD_LD;
        end
      end
      ST_ADDR: begin
        if (tc) begin
          if (HAS_GAP) begin
            state_d = ST_ADDR_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_DATA;
            cnt_d   = HOLD_LD;
          end
        end
      end
      ST_ADDR_GAP: begin
        if (tc) begin
          state_d = ST_DATA;
          cnt_d   = HOLD_LD;
        end
      end
      ST_DATA: begin
        if (tc) begin
          if (!req_q.wr) begin
            rd_valid_d = 1'b1;
            rd_data_d  = di_i;
          end
          if (HAS_GAP) begin
            state_d = ST_DATA_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d  = ST_IDLE;
            dispatch = 1'b1;
          end
        end
      end
      ST_DATA_GAP: begin
        if (tc) begin
          state_d  = ST_IDLE;
          dispatch = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Finishing a request and starting the next share one clock: no idle bubble.
    if (dispatch && !fifo_empty) begin
      pop     = 1'b1;
      req_d   = head;
      cnt_d   = HOLD_LD;
      state_d = (head.chip != cur_chip_q) ? ST_SEL : ST_ADDR;
    end

    bus_d = bus_word(state_d, req_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      cur_chip_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      bus_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      cur_chip_q <= cur_chip_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      bus_q      <= bus_d;
    end
  end

  assign {bdir_o, bc_o} = bus_q[9:8];
  assign do_o           = bus_q[7:0];
  assign rd_valid_o     = rd_valid_q;
  assign rd_data_o      = rd_data_q;
  assign req_ready_o    = !fifo_full;
  assign busy_o         = !fifo_empty || (state_q != ST_IDLE);

endmodule
